// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter.
//   owner_e     : which master issued a transaction (0 = fetch, 1 = data)
//   mem_size_e  : memory access size encodings
//   mem_cmd_t   : address-phase fields driven onto the memory port
//   inst_cmd()  : builds the fixed-format command for an instruction fetch
package sram_req_arbiter_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } mem_cmd_t;

  // Fetches are always full-word reads.
  function automatic mem_cmd_t inst_cmd(input logic [31:0] addr);
    mem_cmd_t c;
    c.wr    = 1'b0;
    c.size  = SIZE_WORD;
    c.addr  = addr;
    c.wstrb = 4'b0000;
    c.wdata = 32'h0;
    return c;
  endfunction

endpackage

// File: rtl/sram_req_arbiter_owner_fifo.sv
// In-order tracker of which master owns each accepted-but-unanswered
// memory transaction. One-bit entries, same-cycle push and pop supported.
//   clk, reset  : clock, synchronous active-high reset
//   push        : record push_owner at the tail (ignored when full)
//   push_owner  : owner id of the transaction just accepted
//   pop         : retire the head entry (ignored when empty)
//   head_owner  : owner id of the oldest outstanding transaction
//   count       : number of outstanding entries
//   full, empty : occupancy flags
module sram_req_arbiter_owner_fifo
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  owner_e                     push_owner,
  input  logic                       pop,
  output owner_e                     head_owner,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  owner_e             owner_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count/pointers
  // define which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) owner_mem[wr_ptr] <= push_owner;
  end

  assign head_owner = owner_mem[rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch master
// (read-only) and the data master (load/store). Arbitrates address phases,
// holds a grant until its address phase is accepted, tracks outstanding
// transactions in order, and routes each response to its issuer.
//   clk, reset        : clock, synchronous active-high reset
//   inst_*            : fetch master request / address-ok / response
//   data_*            : data master request / address-ok / response
//   mem_*             : memory port request and response
//   proto_err         : sticky, response seen with nothing outstanding
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                lock_valid;
  owner_e              lock_owner;
  logic [STARVE_W-1:0] starve_cnt;
  logic                grant_valid;
  owner_e              grant_owner;
  logic                starve_force;
  logic                accept;
  logic                resp_pop;
  owner_e              head_owner;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  mem_cmd_t            cmd;

  // Fetch has waited through STARVE_LIMIT data grants: it wins this time.
  assign starve_force = inst_req && (starve_cnt == STARVE_W'(STARVE_LIMIT));

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    if (lock_valid) begin
      // A stalled address phase keeps its owner until memory takes it.
      grant_owner = lock_owner;
      grant_valid = (lock_owner == OWNER_DATA) ? data_req : inst_req;
    end else if (data_req && !starve_force) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_DATA;
    end else if (inst_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_INST;
    end
  end

  // No issue while the tracker is full; the slot freed by a response only
  // becomes usable on the following cycle.
  assign mem_req = grant_valid & ~fifo_full;

  always_comb begin
    cmd = '0;
    if (mem_req) begin
      if (grant_owner == OWNER_DATA) begin
        cmd = '{wr: data_wr, size: data_size, addr: data_addr,
                wstrb: data_wstrb, wdata: data_wdata};
      end else begin
        cmd = inst_cmd(inst_addr);
      end
    end
  end

  assign mem_wr    = cmd.wr;
  assign mem_size  = cmd.size;
  assign mem_addr  = cmd.addr;
  assign mem_wstrb = cmd.wstrb;
  assign mem_wdata = cmd.wdata;

  assign accept       = mem_req & mem_addr_ok;
  assign inst_addr_ok = accept & (grant_owner == OWNER_INST);
  assign data_addr_ok = accept & (grant_owner == OWNER_DATA);

  // A response with nothing outstanding is not routed anywhere.
  assign resp_pop     = mem_data_ok & ~fifo_empty;
  assign inst_data_ok = resp_pop & (head_owner == OWNER_INST);
  assign data_data_ok = resp_pop & (head_owner == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'h0;

  sram_req_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_owner (grant_owner),
    .pop        (resp_pop),
    .head_owner (head_owner),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid <= 1'b0;
      lock_owner <= OWNER_INST;
      starve_cnt <= '0;
      proto_err  <= 1'b0;
    end else begin
      // Lock on a stalled address phase, release on the accepting edge.
      lock_valid <= mem_req & ~mem_addr_ok;
      lock_owner <= grant_owner;

      if (mem_data_ok && fifo_empty) proto_err <= 1'b1;

      if (!inst_req || inst_addr_ok) begin
        starve_cnt <= '0;
      end else if (data_addr_ok && (starve_cnt != STARVE_W'(STARVE_LIMIT))) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  // Occupancy flag and count must always agree.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (fifo_full == (fifo_count == CNT_W'(MAX_OUTSTANDING)));
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
module tb_sram_req_arbiter;

  localparam int MAX_OUT = 4;
  localparam int STARVE  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .MAX_OUTSTANDING (MAX_OUT),
    .STARVE_LIMIT    (STARVE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wstrb    (mem_wstrb),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .proto_err    (proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: explicit overrides, otherwise a fixed scramble of the address.
  logic [31:0] mem_arr [logic [31:0]];
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  // Scoreboard entry: who must receive the response and what data it carries.
  typedef struct {
    int          owner;     // 0 = inst, 1 = data
    bit          chk_rdata; // loads and fetches only
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb_q [$];    // expected responses, issue order
  logic [31:0] mem_q [$];   // memory-side pending read data, accept order

  // Reference-model state
  bit m_lock;
  int m_lock_owner;
  int m_starve;
  bit m_proto;
  bit inst_acc;
  bit data_acc;

  // Observation counters (from the DUT's handshakes)
  int data_run;
  int last_run;
  int dut_acc_cnt;
  int dut_resp_cnt;

  // Monitor / reference model: evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    bit          full;
    bit          gv;
    bit          exp_req;
    bit          acc;
    bit          exp_resp;
    bit          dut_resp;
    bit          was_empty;
    int          gown;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    exp_t        e;
    exp_t        ne;

    if (reset) begin
      sb_q.delete();
      mem_q.delete();
      m_lock       = 1'b0;
      m_lock_owner = 0;
      m_starve     = 0;
      m_proto      = 1'b0;
      inst_acc     = 1'b0;
      data_acc     = 1'b0;
      data_run     = 0;
      dut_acc_cnt  = 0;
      dut_resp_cnt = 0;
    end else begin
      full = (sb_q.size() >= MAX_OUT);
      gv   = 1'b0;
      gown = 0;
      if (m_lock) begin
        gown = m_lock_owner;
        gv   = (gown == 1) ? data_req : inst_req;
      end else if (data_req && !(inst_req && m_starve == STARVE)) begin
        gv   = 1'b1;
        gown = 1;
      end else if (inst_req) begin
        gv   = 1'b1;
        gown = 0;
      end
      exp_req = gv && !full;

      e_wr = 1'b0; e_size = 2'd0; e_addr = 32'h0; e_wstrb = 4'h0; e_wdata = 32'h0;
      if (exp_req && gown == 1) begin
        e_wr = data_wr; e_size = data_size; e_addr = data_addr;
        e_wstrb = data_wstrb; e_wdata = data_wdata;
      end else if (exp_req) begin
        e_size = 2'd2; e_addr = inst_addr;
      end

      check("mem_req", mem_req, exp_req);
      check("mem_wr", mem_wr, e_wr);
      check("mem_size", mem_size, e_size);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wstrb", mem_wstrb, e_wstrb);
      check("mem_wdata", mem_wdata, e_wdata);

      acc      = exp_req && mem_addr_ok;
      inst_acc = acc && gown == 0;
      data_acc = acc && gown == 1;
      check("inst_addr_ok", inst_addr_ok, inst_acc);
      check("data_addr_ok", data_addr_ok, data_acc);

      // Response side: compare whenever the DUT presents a response.
      was_empty = (sb_q.size() == 0);
      exp_resp  = mem_data_ok && !was_empty;
      dut_resp  = inst_data_ok || data_data_ok;
      check("resp_present", dut_resp, exp_resp);
      if (!was_empty && (dut_resp || exp_resp)) begin
        e = sb_q.pop_front();
        check("resp_owner", {inst_data_ok, data_data_ok}, (e.owner == 1) ? 2'b01 : 2'b10);
        if (e.chk_rdata)
          check("resp_rdata", (e.owner == 1) ? data_rdata : inst_rdata, e.rdata);
      end

      check("proto_err", proto_err, m_proto);
      if (mem_data_ok && was_empty) m_proto = 1'b1;

      if (acc) begin
        ne.owner     = gown;
        ne.chk_rdata = (gown == 0) || !data_wr;
        ne.rdata     = mem_read((gown == 1) ? data_addr : inst_addr);
        sb_q.push_back(ne);
      end

      // Memory side reacts to what the DUT actually drives.
      if (mem_req && mem_addr_ok) mem_q.push_back(mem_read(mem_addr));

      m_lock       = exp_req && !mem_addr_ok;
      m_lock_owner = gown;

      if (!inst_req || inst_acc) m_starve = 0;
      else if (data_acc && m_starve < STARVE) m_starve++;

      if (inst_addr_ok || data_addr_ok) dut_acc_cnt++;
      if (dut_resp) dut_resp_cnt++;
      if (!inst_req) data_run = 0;
      else if (inst_addr_ok) begin
        last_run = data_run;
        data_run = 0;
      end else if (data_addr_ok) data_run++;
    end
  end

  // One cycle of masters + memory behaviour. Requests are held until accepted.
  task automatic drive_cycle(input int p_inst, input int p_data, input int p_aok, input int p_dok);
    @(posedge clk); #1;
    if (!inst_req || inst_acc) begin
      inst_req  = ($urandom_range(99) < p_inst);
      inst_addr = $urandom & 32'hFFFF_FFFC;
    end
    if (!data_req || data_acc) begin
      data_req   = ($urandom_range(99) < p_data);
      data_wr    = 1'($urandom_range(1));
      data_size  = 2'($urandom_range(2));
      data_addr  = $urandom;
      data_wstrb = 4'($urandom);
      data_wdata = $urandom;
    end
    mem_addr_ok = ($urandom_range(99) < p_aok);
    if (mem_q.size() > 0 && $urandom_range(99) < p_dok) begin
      mem_data_ok = 1'b1;
      mem_rdata   = mem_q.pop_front();
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset       = 1'b1;
    inst_req    = 1'b0;
    data_req    = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'h0;
    data_wstrb = 4'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    last_run = -1;
    mem_arr[32'h0000_1000] = 32'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state: idle port, no acks, no error.
    @(negedge clk);
    check("reset mem_req", mem_req, 1'b0);
    check("reset addr_oks", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("reset proto_err", proto_err, 1'b0);

    // Response with nothing outstanding: no routing, sticky error.
    @(posedge clk); #1 mem_data_ok = 1'b1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("stray data_oks", {inst_data_ok, data_data_ok}, 2'b00);
    @(posedge clk); #1 mem_data_ok = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("proto_err sticky", proto_err, 1'b1);
    do_reset(2);
    @(negedge clk);
    check("proto_err cleared", proto_err, 1'b0);

    // Single load: accepted same cycle, answered two cycles later.
    @(posedge clk); #1;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_1000;
    data_wstrb = 4'h0; data_wdata = 32'h0; mem_addr_ok = 1'b1;
    @(negedge clk);
    check("load data_addr_ok", data_addr_ok, 1'b1);
    check("load mem_addr", mem_addr, 32'h0000_1000);
    @(posedge clk); #1 data_req = 1'b0; mem_addr_ok = 1'b0;
    @(posedge clk); #1;
    mem_data_ok = 1'b1;
    mem_rdata   = (mem_q.size() > 0) ? mem_q.pop_front() : 32'hDEAD_BEEF;
    @(negedge clk);
    check("load data_data_ok", data_data_ok, 1'b1);
    check("load data_rdata", data_rdata, 32'hDEAD_BEEF);
    check("load inst_data_ok", inst_data_ok, 1'b0);
    @(posedge clk); #1 mem_data_ok = 1'b0;

    // Two outstanding, then reset: tracking must start over from empty.
    repeat (2) drive_cycle(0, 100, 100, 0);
    do_reset(2);

    // Fill to the outstanding limit with no responses.
    repeat (8) drive_cycle(100, 100, 100, 0);
    @(negedge clk);
    check("full mem_req", mem_req, 1'b0);
    check("full addr_oks", {inst_addr_ok, data_addr_ok}, 2'b00);
    drive_cycle(100, 100, 100, 100);  // one response frees a slot
    drive_cycle(100, 100, 100, 0);
    @(negedge clk);
    check("slot reused mem_req", mem_req, 1'b1);

    // Drain, then starvation: both always requesting, memory always ready.
    repeat (12) drive_cycle(0, 0, 0, 100);
    repeat (4) drive_cycle(0, 0, 100, 100);
    last_run = -1;
    repeat (24) drive_cycle(100, 100, 100, 100);
    check("starve data run", last_run, STARVE);

    // Random traffic with stalls, back-pressure and varying mixes.
    for (int blk = 0; blk < 30; blk++) begin
      int pi, pd, pa, pr;
      pi = $urandom_range(20, 100);
      pd = $urandom_range(20, 100);
      pa = $urandom_range(20, 100);
      pr = $urandom_range(10, 90);
      repeat (100) drive_cycle(pi, pd, pa, pr);
    end

    // Drain everything outstanding, bounded.
    n = 0;
    while ((mem_q.size() > 0 || inst_req || data_req) && n < 200) begin
      drive_cycle(0, 0, 100, 100);
      n++;
    end
    check("drain timeout", (n < 200), 1'b1);
    drive_cycle(0, 0, 100, 100);
    @(negedge clk);
    check("accepts answered", dut_resp_cnt, dut_acc_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_req_arbiter.md
Name: sram_req_arbiter

Overview:
Shares one SRAM-like memory port between the instruction-fetch master (read-only) and the data-access master (load/store from EXE/MEM). It arbitrates requests, locks a grant until the address phase is accepted, tracks outstanding transactions in order, and routes each response (data_ok/rdata) back to the master that issued it. It sits between the CPU core pipeline and the memory-side bridge.

Parameters:
MAX_OUTSTANDING, 4, maximum in-flight accepted-but-unanswered transactions (power of 2, >=2)
STARVE_LIMIT, 4, consecutive data grants with inst pending before inst is forced

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request, held until inst_addr_ok
inst_addr  in  32  fetch address
inst_addr_ok  out  1  fetch address phase accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  32  fetch read data
data_req  in  1  data request, held until data_addr_ok
data_wr  in  1  1=store, 0=load
data_size  in  2  0=byte, 1=half, 2=word
data_addr  in  32  data address
data_wstrb  in  4  store byte strobes
data_wdata  in  32  store data
data_addr_ok  out  1  data address phase accepted this cycle
data_data_ok  out  1  data response valid (load data or store ack)
data_rdata  out  32  load read data
mem_req  out  1  request to memory port
mem_wr  out  1  write flag
mem_size  out  2  size
mem_addr  out  32  address
mem_wstrb  out  4  strobes
mem_wdata  out  32  write data
mem_addr_ok  in  1  memory accepted address phase
mem_data_ok  in  1  memory response valid
mem_rdata  in  32  memory read data
proto_err  out  1  sticky: mem_data_ok seen with no outstanding transaction

Behaviour:
- Reset: owner FIFO empty, count 0, grant lock cleared, starvation counter 0, proto_err 0. All mem_* outputs and *_ok outputs combinational; 0 when no request is present.
- Issue allowed only when count < MAX_OUTSTANDING; when full, mem_req=0 and both *_addr_ok=0.
- Grant select (combinational, when unlocked): data if data_req and not (inst_req and starve_cnt==STARVE_LIMIT); else inst if inst_req.
- Grant lock: if mem_req=1 and mem_addr_ok=0, lock register records current owner; next cycles grant that owner regardless of priority until mem_addr_ok=1, then unlock same edge.
- Inst grant drives mem_wr=0, mem_size=2, mem_wstrb=0, mem_wdata=0, mem_addr=inst_addr. Data grant forwards all data_* fields.
- {owner}_addr_ok = mem_addr_ok & mem_req & (grant==owner); zero-latency, same cycle.
- Accept (mem_req & mem_addr_ok): push owner id (0=inst,1=data) into owner FIFO.
- Response (mem_data_ok): pop FIFO head; assert {head}_data_ok, rdata = mem_rdata same cycle; other master's data_ok=0. Responses are strictly in order.
- Push and pop same cycle: count unchanged; legal at full (pop frees slot only next cycle; no push while full).
- mem_data_ok with FIFO empty: no pop, no *_data_ok, proto_err<=1 until reset.
- Starvation counter: increments on each data accept while inst_req=1; clears on inst accept or when inst_req=0; saturates at STARVE_LIMIT.
- Reset mid-operation: all in-flight tracking discarded; memory side must be reset in the same cycle.

Decomposition:
- Shared header mycpu.h: owner id encodings (OWNER_INST=0, OWNER_DATA=1), size encodings.
- One sub-module: owner_fifo (synchronous FIFO, 1-bit entries, depth MAX_OUTSTANDING, count/full/empty outputs, same-cycle push+pop).

Test Plan:
- data load 0x1000, mem_addr_ok same cycle, mem_data_ok 2 cycles later with 0xDEADBEEF -> data_addr_ok=1 cycle 0, data_data_ok=1, data_rdata=0xDEADBEEF, inst_data_ok=0.
- inst_req and data_req same cycle, mem_addr_ok always 1 -> data accepted cycle 0, inst cycle 1; responses return data then inst in order.
- inst_req with mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays inst_addr until accept; data granted next cycle.
- 4 loads accepted, no responses -> 5th request sees mem_req=0; mem_data_ok -> head popped, new request accepted following cycle.
- data_req held continuously, inst_req pending, STARVE_LIMIT=4 -> 4 data accepts, then inst accepted on 5th, counter reset.
- mem_data_ok with empty FIFO -> proto_err=1 sticky, no *_data_ok; reset with 2 outstanding -> count 0, proto_err 0.
